// File: rtl/cchw_pkg.sv
// Shared types and constants for the LED frame path.
package CCHW;

  typedef enum logic [1:0] {IDLE, WAIT, LATCH, STREAM} LfsState_t;

  localparam int unsigned RGB_W = 24;

endpackage

// File: rtl/led_run_expander.sv
// Snapshots LV bin colours/counts and expands them into one LEDS-word strip frame.
// LED_FRAME_REVERSE_EN: scan bins from BIN_QTY-1 down to 0 instead of 0 upwards.
module led_run_expander
  import CCHW::*;
#(
  parameter int unsigned BIN_QTY = 12,
  parameter int unsigned LEDS    = 50
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     load,
  input  logic                                     stream,
  input  logic [BIN_QTY-1:0][RGB_W-1:0]            rgb,
  input  logic [BIN_QTY-1:0][$clog2(LEDS)-1:0]     led_counts,
  input  logic                                     led_rdy,
  output logic [RGB_W-1:0]                         led_rgb,
  output logic                                     led_v,
  output logic                                     frame_last,
  output logic                                     frame_done
);

  localparam int unsigned CntW  = $clog2(LEDS);
  localparam int unsigned WordW = $clog2(LEDS + 1);
  localparam int unsigned BinW  = $clog2(BIN_QTY + 1);

  logic [BIN_QTY-1:0][RGB_W-1:0] rgb_q;
  logic [BIN_QTY-1:0][CntW-1:0]  run_q;
  logic [WordW-1:0]              word_q;

  logic [BinW-1:0]    bin_idx;
  logic [BIN_QTY-1:0] pick;
  logic [RGB_W-1:0]   sel_rgb;
  logic               pad;
  logic               xfer;

  // Priority scan over remaining run lengths: empty bins cost no cycles.
  // The last matching iteration wins, so the loop runs opposite to stream order.
  always_comb begin
    bin_idx = BinW'(BIN_QTY);
`ifdef LED_FRAME_REVERSE_EN
    for (int i = 0; i < int'(BIN_QTY); i++) begin
      if (run_q[i] != '0) bin_idx = BinW'(i);
    end
`else
    for (int i = int'(BIN_QTY) - 1; i >= 0; i--) begin
      if (run_q[i] != '0) bin_idx = BinW'(i);
    end
`endif
    pick    = '0;
    sel_rgb = '0;
    for (int i = 0; i < int'(BIN_QTY); i++) begin
      if (bin_idx == BinW'(i)) begin
        pick[i] = 1'b1;
        sel_rgb = rgb_q[i];
      end
    end
  end

  assign pad        = (bin_idx == BinW'(BIN_QTY));
  assign led_v      = stream;
  assign led_rgb    = stream ? sel_rgb : '0;
  assign frame_last = stream && (word_q == WordW'(LEDS - 1));
  assign xfer       = stream && led_rdy;
  assign frame_done = xfer && frame_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q  <= '0;
      run_q  <= '0;
      word_q <= '0;
    end else if (load) begin
      rgb_q  <= rgb;
      run_q  <= led_counts;
      word_q <= '0;
    end else if (xfer) begin
      word_q <= word_q + WordW'(1);
      for (int i = 0; i < int'(BIN_QTY); i++) begin
        if (pick[i] && !pad) run_q[i] <= run_q[i] - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Starts LV on a note frame, waits its latency, then streams one LED frame.
// LED_FRAME_REVERSE_EN (see led_run_expander) reverses bin order in the frame.
module led_frame_sequencer
  import CCHW::*;
#(
  parameter int unsigned BIN_QTY    = 12,
  parameter int unsigned LEDS       = 50,
  parameter int unsigned LV_LATENCY = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 notes_v,
  output logic                                 notes_ack,
  output logic                                 lv_start,
  input  logic                                 lv_data_v,
  input  logic [BIN_QTY-1:0][RGB_W-1:0]        rgb,
  input  logic [BIN_QTY-1:0][$clog2(LEDS)-1:0] led_counts,
  output logic [RGB_W-1:0]                     led_rgb,
  output logic                                 led_v,
  input  logic                                 led_rdy,
  output logic                                 frame_last,
  output logic                                 busy
);

  localparam int unsigned WaitW = $clog2(LV_LATENCY + 1);

  LfsState_t        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    notes_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        notes_ack = notes_v;
        if (notes_v) begin
          state_d = WAIT;
          wait_d  = WaitW'(LV_LATENCY - 1);
        end
      end
      WAIT: begin
        // Counter parks at zero until LV reports valid data.
        if (wait_q != '0) wait_d = wait_q - WaitW'(1);
        else if (lv_data_v) state_d = LATCH;
      end
      LATCH:   state_d = STREAM;
      STREAM:  if (frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lv_start = notes_ack;
  assign busy     = (state_q != IDLE);

  led_run_expander #(
    .BIN_QTY (BIN_QTY),
    .LEDS    (LEDS)
  ) u_expander (
    .clk        (clk),
    .rst        (rst),
    .load       (state_q == LATCH),
    .stream     (state_q == STREAM),
    .rgb        (rgb),
    .led_counts (led_counts),
    .led_rdy    (led_rdy),
    .led_rgb    (led_rgb),
    .led_v      (led_v),
    .frame_last (frame_last),
    .frame_done (frame_done)
  );

endmodule
